demux16_seq: RTL and testbench
==============================

DEMUX16_SEQ -- requirements
Module: demux16_seq

Interface
REQ-001 The block SHALL have one clock and one synchronous, active-high reset, with ports listed clock and reset first.
REQ-002 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port reset: input, 1 bit, synchronous active-high reset.
REQ-004 Port din: input, 1 bit, serial data bit to be routed to one output lane.
REQ-005 Port din_valid: input, 1 bit; din is accepted on each rising edge where din_valid=1.
REQ-006 Port sel: input, [0:3], destination lane index in manual mode; ignored in auto mode.
REQ-007 Port auto_mode: input, 1 bit; 0 selects manual (addressed) mode, 1 selects auto-increment frame mode.
REQ-008 Port clear: input, 1 bit, synchronous abort of any partial auto frame.
REQ-009 Port dout: output, [0:15], registered lane outputs; dout[0] is lane 0 (MSB position).
REQ-010 Port frame_valid: output, 1 bit, registered one-cycle pulse marking a completed auto frame.
REQ-011 Port ptr: output, [0:3], current auto-mode fill pointer (next lane to be written).
REQ-012 Port busy: output, 1 bit; 1 while a partial auto frame is held (FSM in FILL).

Function
REQ-013 The FSM SHALL have exactly two states: IDLE (ptr=0, no partial frame) and FILL (1-15 bits captured).
REQ-014 Priority per edge SHALL be: reset > clear > auto_mode=0 > din_valid.
REQ-015 Manual mode: on din_valid=1, dout[sel] <= din next edge; other 15 lanes hold; frame_valid stays 0; latency 1 cycle.
REQ-016 Manual mode: ptr SHALL be held at 0, the 16-bit shadow register cleared, FSM forced to IDLE.
REQ-017 Auto mode: on din_valid=1 with ptr<15, shadow[ptr] <= din, ptr <= ptr+1, FSM -> FILL; dout unchanged.
REQ-018 Auto mode: on din_valid=1 with ptr=15, dout <= {shadow[0:14], din} in one edge, frame_valid=1 for exactly the following cycle, ptr wraps to 0, shadow cleared, FSM -> IDLE.
REQ-019 Back-to-back frames: din_valid held high continuously SHALL yield frame_valid every 16th cycle with no lost bits.
REQ-020 din_valid=0 SHALL hold ptr, shadow, dout and FSM state indefinitely (gaps allowed mid-frame).
REQ-021 clear=1 SHALL set ptr=0, clear shadow, FSM -> IDLE, frame_valid=0; dout holds; din that cycle is discarded.
REQ-022 Switching auto_mode 1->0 mid-frame SHALL discard the partial frame per REQ-016; dout holds its last value.
REQ-023 Switching auto_mode 0->1 SHALL start a frame at lane 0 on the first subsequent din_valid.
REQ-024 busy SHALL equal (FSM==FILL); ptr output SHALL equal the internal pointer register.

Reset
REQ-025 On reset=1 at a rising edge: dout=16'b0, frame_valid=0, ptr=0, busy=0, shadow=0, FSM=IDLE.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame and suppress any frame_valid pulse for that edge.
REQ-027 All outputs SHALL be valid (non-X) from the first edge after reset.

Verification
REQ-028 Manual walk: auto_mode=0, for sel=0..15 apply din=1, din_valid=1 one cycle each -> dout fills 1000..., 1100..., ending 16'hFFFF; frame_valid never 1.
REQ-029 Auto frame: auto_mode=1, stream 16 bits 1010_0000_0000_0001 -> dout=16'b1010000000000001 one cycle after 16th bit, frame_valid one cycle, ptr=0, busy=0.
REQ-030 Gapped input: same frame with din_valid=0 for 3 cycles after bit 7 -> identical dout; ptr holds 8 during gap, busy=1.
REQ-031 Clear mid-frame: 5 bits then clear=1, then full 16-bit frame 16'hF00F -> dout=16'hF00F only, frame_valid pulses once.
REQ-032 Reset mid-frame: 10 bits then reset=1 -> dout=0, ptr=0, busy=0, no frame_valid; next 16 bits 16'h8001 -> dout=16'h8001.
REQ-033 Back-to-back: 32 consecutive valid bits (16'hAAAA then 16'h5555) -> frame_valid on cycles 17 and 33 after start, dout=16'hAAAA then 16'h5555.

Source files
------------

// File: rtl/demux16_seq_if.sv
// Bundle of the serial-in / 16-lane-out signals of demux16_seq.
// master drives the serial side; slave is the demultiplexer itself.
interface demux16_seq_if;
   logic        din;
   logic        din_valid;
   logic [0:3]  sel;
   logic        auto_mode;
   logic        clear;
   logic [0:15] dout;
   logic        frame_valid;
   logic [0:3]  ptr;
   logic        busy;

   modport master (
      output din, din_valid, sel, auto_mode, clear,
      input  dout, frame_valid, ptr, busy
   );

   modport slave (
      input  din, din_valid, sel, auto_mode, clear,
      output dout, frame_valid, ptr, busy
   );
endinterface

// File: rtl/demux16_seq.sv
// Serial-to-16-lane demultiplexer: addressed single-lane writes in manual mode,
// or 16-bit frame assembly with an auto-incrementing fill pointer in auto mode.
module demux16_seq (
   input  logic               clk,
   input  logic               reset,
   demux16_seq_if.slave       bus
);

   typedef enum logic {
      IDLE,
      FILL
   } state_e;

   state_e      state_q;
   logic [0:15] dout_q;
   logic [0:15] shadow_q;
   logic [0:3]  ptr_q;
   logic        frame_valid_q;

   logic [0:15] dout_man_d;
   logic [0:15] frame_d;
   logic [0:15] shadow_d;

   always_comb begin
      dout_man_d            = dout_q;
      dout_man_d[bus.sel]   = bus.din;
      shadow_d              = shadow_q;
      shadow_d[ptr_q]       = bus.din;
      // Lane 15 of a completed frame comes straight from din, not the shadow.
      frame_d               = {shadow_q[0:14], bus.din};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         dout_q        <= '0;
         shadow_q      <= '0;
         ptr_q         <= '0;
         frame_valid_q <= 1'b0;
      end else begin
         frame_valid_q <= 1'b0;
         if (bus.clear) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            ptr_q    <= '0;
         end else if (!bus.auto_mode) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            ptr_q    <= '0;
            if (bus.din_valid) begin
               dout_q <= dout_man_d;
            end
         end else if (bus.din_valid) begin
            if (ptr_q == 4'd15) begin
               dout_q        <= frame_d;
               frame_valid_q <= 1'b1;
               shadow_q      <= '0;
               ptr_q         <= '0;
               state_q       <= IDLE;
            end else begin
               shadow_q <= shadow_d;
               ptr_q    <= ptr_q + 4'd1;
               state_q  <= FILL;
            end
         end
      end
   end

   assign bus.dout        = dout_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.ptr         = ptr_q;
   assign bus.busy        = (state_q == FILL);

endmodule

// File: tb/tb_demux16_seq.sv
// Bench for demux16_seq: directed scenarios plus random traffic, checked
// against a queue-based frame model.
module tb_demux16_seq;

   logic clk = 1'b0;
   logic reset;
   demux16_seq_if bus ();

   demux16_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   string       phase  = "init";

   bit m_dout[16];
   bit m_bits[$];
   bit m_fv;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s/%s: got %h expected %h", phase, tag, got, exp);
   endtask

   function automatic logic [15:0] m_vec();
      logic [15:0] v;
      for (int i = 0; i < 16; i++) v[15-i] = m_dout[i];
      return v;
   endfunction

   function automatic logic [15:0] dut_vec();
      logic [15:0] v;
      v = bus.dout;
      return v;
   endfunction

   // Apply one cycle of inputs, advance the model, then compare every output.
   task automatic step(input bit rst, input bit clr, input bit am, input bit dv,
                       input bit d, input int unsigned s);
      reset         = rst;
      bus.clear     = clr;
      bus.auto_mode = am;
      bus.din_valid = dv;
      bus.din       = d;
      bus.sel       = 4'(s);
      @(posedge clk);
      m_fv = 1'b0;
      if (rst) begin
         foreach (m_dout[i]) m_dout[i] = 1'b0;
         m_bits.delete();
      end else if (clr) begin
         m_bits.delete();
      end else if (!am) begin
         m_bits.delete();
         if (dv) m_dout[s] = d;
      end else if (dv) begin
         m_bits.push_back(d);
         if (m_bits.size() == 16) begin
            foreach (m_dout[i]) m_dout[i] = m_bits[i];
            m_fv = 1'b1;
            m_bits.delete();
         end
      end
      #1;
      check("dout", dut_vec(), m_vec());
      check("frame_valid", {15'b0, bus.frame_valid}, {15'b0, m_fv});
      check("ptr", {12'b0, bus.ptr}, 16'(m_bits.size()));
      check("busy", {15'b0, bus.busy}, {15'b0, m_bits.size() != 0});
   endtask

   task automatic auto_bits(input logic [15:0] w, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(0, 0, 1, 1, w[15-i], 0);
   endtask

   task automatic idle(input bit am, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(0, 0, am, 0, 1, 0);
   endtask

   initial begin
      reset = 1'b1; bus.clear = 1'b0; bus.auto_mode = 1'b0;
      bus.din_valid = 1'b0; bus.din = 1'b0; bus.sel = '0;
      foreach (m_dout[i]) m_dout[i] = 1'b0;
      m_fv = 1'b0;

      phase = "reset";
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 1, 3);
      check("dout0", dut_vec(), 16'h0000);
      check("ptr0", {12'b0, bus.ptr}, 16'h0000);

      phase = "manual_walk";
      for (int unsigned s = 0; s < 16; s++) step(0, 0, 0, 1, 1, s);
      check("walk_end", dut_vec(), 16'hFFFF);

      phase = "auto_frame";
      idle(1, 2);
      auto_bits(16'hA001, 16);
      check("frame", dut_vec(), 16'hA001);
      check("frame_fv", {15'b0, bus.frame_valid}, 16'h0001);
      check("frame_ptr", {12'b0, bus.ptr}, 16'h0000);
      check("frame_busy", {15'b0, bus.busy}, 16'h0000);
      idle(1, 1);

      phase = "gapped";
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 2);
      auto_bits(16'hA001, 8);
      idle(1, 3);
      check("gap_ptr", {12'b0, bus.ptr}, 16'h0008);
      check("gap_busy", {15'b0, bus.busy}, 16'h0001);
      for (int unsigned i = 8; i < 16; i++) step(0, 0, 1, 1, (16'hA001 >> (15 - i)) & 1, 0);
      check("gap_frame", dut_vec(), 16'hA001);

      phase = "clear";
      auto_bits(16'hFFFF, 5);
      step(0, 1, 1, 1, 1, 0);
      auto_bits(16'hF00F, 16);
      check("clear_frame", dut_vec(), 16'hF00F);

      phase = "reset_mid";
      auto_bits(16'h1234, 10);
      step(1, 0, 1, 1, 1, 0);
      check("rst_dout", dut_vec(), 16'h0000);
      auto_bits(16'h8001, 16);
      check("rst_frame", dut_vec(), 16'h8001);
      auto_bits(16'hFFFF, 15);
      step(1, 0, 1, 1, 1, 0);
      check("rst_no_fv", {15'b0, bus.frame_valid}, 16'h0000);

      phase = "back_to_back";
      auto_bits(16'hAAAA, 16);
      check("b2b_first", dut_vec(), 16'hAAAA);
      auto_bits(16'h5555, 16);
      check("b2b_second", dut_vec(), 16'h5555);

      phase = "mode_switch";
      auto_bits(16'hFFFF, 6);
      step(0, 0, 0, 1, 0, 15);
      check("switch_ptr", {12'b0, bus.ptr}, 16'h0000);
      auto_bits(16'hC3C3, 16);
      check("switch_frame", dut_vec(), 16'hC3C3);

      phase = "random";
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 15));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
